// File: rtl/uart_tx_fifo_if.sv
// Byte handshake bundle between uart_rx, the TX FIFO and uart_tx.
// slave = FIFO side, master = environment (rx producer + tx consumer).
interface uart_tx_fifo_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_start;
    logic             tx_idle;

    modport master (
        output in_data, in_ready, tx_idle,
        input  tx_data, tx_start
    );

    modport slave (
        input  in_data, in_ready, tx_idle,
        output tx_data, tx_start
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO echoing uart_rx bytes into uart_tx, one frame at a time.
// Optional drop statistics counter enabled by defining UART_TX_FIFO_STATS_EN.
module uart_tx_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_N,
    uart_tx_fifo_if.slave bus,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic [7:0]    drop_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_IDLE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             prev_ready;
    logic             wr_req;
    logic             wr_en;
    logic             pop;
    logic [AW:0]      count_nxt;

    // Read-side sequencing; pop is decided from the registered occupancy.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        wr_req    = bus.in_ready & ~prev_ready;
        wr_en     = 1'b0;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!bus.tx_idle) state_nxt = WAIT_IDLE;
            WAIT_IDLE: if (bus.tx_idle)  state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        // A write into a full FIFO still fits when a pop frees a slot this cycle.
        wr_en = wr_req & (~full | pop);
        case ({wr_en, pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev_ready   <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            overflow     <= 1'b0;
            bus.tx_data  <= '0;
            bus.tx_start <= 1'b0;
        end else begin
            prev_ready   <= bus.in_ready;
            count        <= count_nxt;
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == (AW+1)'(DEPTH));
            bus.tx_start <= (state_nxt == START);
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr      <= rd_ptr + AW'(1);
                bus.tx_data <= mem[rd_ptr];
            end
            if (wr_req && !wr_en) overflow <= 1'b1;
        end
    end

    // Storage array carries no reset; contents are qualified by count.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= bus.in_data;
    end

`ifdef UART_TX_FIFO_STATS_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drop_count <= 8'd0;
        end else if (wr_req && !wr_en && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for uart_tx_fifo with a queue-based reference model
// and a behavioural uart_tx stand-in driving tx_idle.
module tb_uart_tx_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          CLK;
    logic          RST_N;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic [7:0]    drop_count;

    uart_tx_fifo_if #(.WIDTH(WIDTH)) bus ();

    uart_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .bus        (bus),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  data;
        int unsigned at;
    } exp_t;

    int           checks = 0;
    int           errors = 0;
    int unsigned  edge_n = 0;
    int unsigned  starts = 0;
    exp_t         sb[$];
    logic [7:0]   mq[$];
    bit           m_prev;
    bit           m_ovf;
    int           m_drops;
    int unsigned  eligible;
    bit           hold;
    int           busy_left;
    int           busy_len;
    logic [7:0]   last_tx = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic int exp_drops();
`ifdef UART_TX_FIFO_STATS_EN
        return m_drops;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_prev   = 1'b0;
        m_ovf    = 1'b0;
        m_drops  = 0;
        eligible = 0;
    endtask

    // Reference: a pop happens at the first edge where the transmitter is free and
    // the queue held data before this edge; a write fits if room remains after that pop.
    task automatic model_edge();
        bit pop;
        bit wr;
        pop    = (edge_n >= eligible) && (mq.size() > 0);
        wr     = bus.in_ready && !m_prev;
        m_prev = bus.in_ready;
        if (pop) begin
            sb.push_back('{data: mq.pop_front(), at: edge_n});
            eligible = 32'hFFFF_FFFF;
        end
        if (wr) begin
            if (mq.size() < DEPTH) mq.push_back(bus.in_data);
            else begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
    endtask

    // uart_tx stand-in: busy for busy_len cycles after each start; frees the FIFO 2 edges later.
    task automatic tx_drive();
        if (bus.tx_start) begin
            bus.tx_idle = 1'b0;
            busy_left   = busy_len;
        end else if (!bus.tx_idle && !hold) begin
            if (busy_left > 0) busy_left--;
            if (busy_left == 0) begin
                bus.tx_idle = 1'b1;
                eligible    = edge_n + 2;
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        edge_n++;
        if (RST_N) model_edge();
        #1;
        tx_drive();
    endtask

    task automatic write_byte(input logic [7:0] d);
        bus.in_ready = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_ready = 1'b0;
        step();
    endtask

    task automatic drain(input string name);
        hold         = 1'b0;
        bus.in_ready = 1'b0;
        for (int i = 0; i < 20000 && (sb.size() > 0 || mq.size() > 0); i++) step();
        step();
        check(name, 32'(sb.size() + mq.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        check({tag, "_tx_data"},  32'(bus.tx_data),  32'd0);
        check({tag, "_count"},    32'(count),        32'd0);
        check({tag, "_empty"},    32'(empty),        32'd1);
        check({tag, "_full"},     32'(full),         32'd0);
        check({tag, "_overflow"}, 32'(overflow),     32'd0);
        check({tag, "_drops"},    32'(drop_count),   32'd0);
    endtask

    // Monitor: consumes expected frames on each start pulse and tracks status outputs.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (bus.tx_start) begin
                starts++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got tx_data %0h expected no pulse (edge %0d)",
                             bus.tx_data, edge_n);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("start_edge", edge_n, e.at);
                    check("tx_data", 32'(bus.tx_data), 32'(e.data));
                end
            end else begin
                check("tx_data_hold", 32'(bus.tx_data), 32'(last_tx));
            end
            if (sb.size() > 0 && sb[0].at < edge_n) begin
                checks++;
                errors++;
                $display("FAIL missing_start: got no pulse expected data %0h at edge %0d",
                         sb[0].data, sb[0].at);
                void'(sb.pop_front());
            end
            check("count",    32'(count),      32'(mq.size()));
            check("empty",    32'(empty),      32'(mq.size() == 0));
            check("full",     32'(full),       32'(mq.size() == DEPTH));
            check("overflow", 32'(overflow),   32'(m_ovf));
            check("drops",    32'(drop_count), 32'(exp_drops()));
        end
        last_tx = bus.tx_data;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish by 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s0;
        RST_N        = 1'b0;
        bus.in_ready = 1'b0;
        bus.in_data  = 8'h00;
        bus.tx_idle  = 1'b1;
        hold         = 1'b0;
        busy_left    = 0;
        busy_len     = 4;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_reset_values("por");
        RST_N = 1'b1;

        // Single byte
        write_byte(8'h41);
        repeat (12) step();
        check("single_starts", starts, 32'd1);
        check("single_count", 32'(count), 32'd0);

        // Burst with long frames
        busy_len = 100;
        for (int i = 0; i < 5; i++) write_byte(8'h31 + 8'(i));
        drain("burst_drain");
        check("burst_starts", starts, 32'd6);

        // Overflow: transmitter stalls after the first pop
        busy_len = 5;
        hold     = 1'b1;
        write_byte(8'h50);
        for (int i = 0; i < 20 && bus.tx_idle; i++) step();
        check("ovf_tx_busy", 32'(bus.tx_idle), 32'd0);
        for (int i = 0; i < DEPTH + 2; i++) write_byte(8'($urandom));
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_count", 32'(count), 32'(DEPTH));
        check("ovf_flag", 32'(overflow), 32'd1);
`ifdef UART_TX_FIFO_STATS_EN
        check("ovf_drops", 32'(drop_count), 32'd2);
`else
        check("ovf_drops", 32'(drop_count), 32'd0);
`endif

        // Full FIFO: write lands on the same edge as the pop
        hold      = 1'b0;
        busy_left = 1;
        step();
        step();
        bus.in_ready = 1'b1;
        bus.in_data  = 8'hA5;
        step();
        bus.in_ready = 1'b0;
        check("full_wr_pop_count", 32'(count), 32'(DEPTH));
        check("full_wr_pop_drops", 32'(drop_count), 32'(exp_drops()));
        busy_len = 3;
        drain("full_wr_pop_drain");

        // Level hold yields a single write
        s0           = starts;
        bus.in_ready = 1'b1;
        bus.in_data  = 8'h7E;
        repeat (50) step();
        bus.in_ready = 1'b0;
        drain("level_drain");
        check("level_one_write", starts - s0, 32'd1);

        // Reset mid-frame
        hold = 1'b1;
        for (int i = 0; i < 4; i++) write_byte(8'h60 + 8'(i));
        repeat (3) step();
        check("rst_pre_busy", 32'(bus.tx_idle), 32'd0);
        RST_N = 1'b0;
        #1;
        check_reset_values("mid_rst");
        model_reset();
        hold        = 1'b0;
        busy_left   = 0;
        bus.tx_idle = 1'b1;
        repeat (2) step();
        RST_N = 1'b1;
        s0    = starts;
        repeat (20) step();
        check("rst_no_restart", starts - s0, 32'd0);

        // Random traffic with occasional transmitter stalls
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(2) == 0) bus.in_ready = ~bus.in_ready;
            if (!bus.in_ready) bus.in_data = 8'($urandom);
            busy_len = 2 + int'($urandom_range(12));
            if ($urandom_range(150) == 0) hold = ~hold;
            step();
        end
        drain("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
